// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths, MMIO word offsets
// and the byte-lane merge helper.
package dmem_responder_pkg;

  localparam logic [1:0] WhbWord = 2'b00;
  localparam logic [1:0] WhbHalf = 2'b01;
  localparam logic [1:0] WhbByte = 2'b10;

  // MMIO register selected by addr[3:2]
  localparam logic [1:0] MmioCnt  = 2'd0;
  localparam logic [1:0] MmioLed  = 2'd1;
  localparam logic [1:0] MmioMis  = 2'd2;
  localparam logic [1:0] MmioZero = 2'd3;

  function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                              input logic [31:0] new_word,
                                              input logic [31:0] old_word);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_bemask.sv
// Store lane decoder: byte enables, lane-replicated store data and misalignment
// from the low address bits and access width.
module dmem_bemask
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  whb_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b1111;
    data_o       = wd_i;
    misaligned_o = 1'b0;
    unique case (whb_i)
      WhbByte: begin
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {4{wd_i[7:0]}};
      end
      WhbHalf: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o       = {2{wd_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      // 2'b11 is handled as a word access
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled RAM, a small MMIO window (cycle counter, LED,
// misalign flag) and a registered trace of every committed store.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [1:0]  whb,
  input  logic [31:0] pc,
  output logic [31:0] rd,
  output logic        misalign,
  output logic [31:0] misalign_pc,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] led
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] ram_idx;
  logic          is_mmio;
  logic [1:0]    mmio_off;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic          misaligned;
  logic          commit;
  logic          ram_we;
  logic [31:0]   merged;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] led_q, led_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_pc_q, misalign_pc_d;
  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [31:0] trace_addr_q, trace_addr_d;
  logic [31:0] trace_data_q, trace_data_d;

  assign ram_idx  = addr[AW+1:2];
  assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = addr[3:2];

  dmem_bemask u_bemask (
    .addr_lo_i    (addr[1:0]),
    .whb_i        (whb),
    .wd_i         (wd),
    .be_o         (be),
    .data_o       (lane_data),
    .misaligned_o (misaligned)
  );

  assign commit = we && !misaligned;
  assign ram_we = commit && !is_mmio && !reset;

  always_comb begin
    rd = mem[ram_idx];
    if (is_mmio) begin
      unique case (mmio_off)
        MmioCnt:  rd = cnt_q;
        MmioLed:  rd = led_q;
        MmioMis:  rd = {31'b0, misalign_q};
        default:  rd = 32'b0;
      endcase
    end
  end

  // The trace reports the word as it will look after the store lands.
  assign merged = merge_bytes(be, lane_data, rd);

  always_comb begin
    cnt_d         = cnt_q + 32'd1;
    led_d         = led_q;
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
    trace_valid_d = commit;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (commit) begin
      trace_pc_d   = pc;
      trace_addr_d = {addr[31:2], 2'b00};
      trace_data_d = merged;
      if (is_mmio && mmio_off == MmioLed) begin
        led_d = merged;
      end
      if (is_mmio && mmio_off == MmioMis && wd[0]) begin
        misalign_d    = 1'b0;
        misalign_pc_d = 32'b0;
      end
    end else if (we && !misalign_q) begin
      misalign_d    = 1'b1;
      misalign_pc_d = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= 32'b0;
      led_q         <= 32'b0;
      misalign_q    <= 1'b0;
      misalign_pc_q <= 32'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'b0;
      trace_addr_q  <= 32'b0;
      trace_data_q  <= 32'b0;
    end else begin
      cnt_q         <= cnt_d;
      led_q         <= led_d;
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  assign led         = led_q;
  assign misalign    = misalign_q;
  assign misalign_pc = misalign_pc_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit RAM words; power of two.
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000, base address of the 16-byte MMIO window.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  store request, sampled at the clk edge (datapath memwriteM).
REQ-006 addr  input  32  byte address (datapath aluoutM).
REQ-007 wd  input  32  store data, unshifted rs2 value (datapath writedataM).
REQ-008 whb  input  2  access width: 2'b00 word, 2'b01 half, 2'b10 byte; 2'b11 treated as word.
REQ-009 pc  input  32  PC of the instruction in MEM (datapath pcM).
REQ-010 rd  output  32  aligned read word at addr[31:2]; the datapath extracts bytes and halfwords.
REQ-011 misalign  output  1  sticky misaligned-store flag.
REQ-012 misalign_pc  output  32  PC of the first misaligned store.
REQ-013 trace_valid  output  1  one-cycle pulse after each committed store.
REQ-014 trace_pc / trace_addr / trace_data  output  32 each  PC, word-aligned address, and merged word of the committed store.
REQ-015 led  output  32  current value of the MMIO output register.

Function
REQ-016 Addresses are RAM when addr[31:4] != MMIO_BASE[31:4], and RAM index = addr[log2(DEPTH_WORDS)+1:2] (upper bits ignored, wraps modulo depth).
REQ-017 rd is combinational from addr and current state; same-cycle store is not visible until the next cycle (read-old).
REQ-018 Byte store writes wd[7:0] to lane addr[1:0]; other lanes are unchanged.
REQ-019 Half store writes wd[15:0] to lanes {addr[1],0} and {addr[1],1}; other lanes are unchanged.
REQ-020 Word store writes all four lanes with wd.
REQ-021 A store is misaligned if half with addr[0]=1, or word with addr[1:0]!=0; a misaligned store writes nothing and produces no trace.
REQ-022 On the first misaligned store after reset, misalign is set to 1 and misalign_pc is set to pc; later misaligned stores leave both unchanged.
REQ-023 MMIO offset 0x0 is a free-running cycle counter: read-only, increments by 1 every cycle, and wraps from 32'hFFFF_FFFF to 0.
REQ-024 MMIO offset 0x4 is the led register: read/write, with byte and half lane merging identical to RAM.
REQ-025 MMIO offset 0x8 reads {31'b0, misalign}; a store of any width with wd[0]=1 clears misalign and misalign_pc.
REQ-026 MMIO offset 0xC reads 0; stores to offsets 0x0 and 0xC are ignored but still traced.
REQ-027 A committed store registers trace_valid=1 with trace_pc=pc, trace_addr={addr[31:2],2'b00} and trace_data=merged word, all visible the cycle after the edge; trace_valid is 0 otherwise.
REQ-028 A misaligned store to offset 0x8 sets the flag (REQ-022) and does not clear it.
REQ-029 RAM contents are uninitialised; an optional $readmemh init file is permitted.

Reset
REQ-030 While reset=1 at an edge: counter=0, led=0, misalign=0, misalign_pc=0, trace_valid=0, trace_pc/addr/data=0.
REQ-031 A store coincident with reset is dropped: RAM is unchanged.
REQ-032 Reset leaves RAM contents unchanged.

Structure
REQ-033 Width encodings (WHB_WORD/HALF/BYTE) and MMIO offsets live in xgriscv_defines.v.
REQ-034 One sub-module, dmem_bemask, is combinational: (addr[1:0], whb, wd) -> 4-bit byte enable, lane-shifted data, misaligned.
REQ-035 RAM is a single reg array with per-byte enables, written in one always block.

Verification
REQ-036 Word store 0x11223344 @0x10, then byte store wd=0xAB @0x12 -> rd@0x10 = 0x11AB3344; trace_data = 0x11AB3344, trace_addr = 0x10.
REQ-037 Half store wd=0xBEEF @0x21, pc=0x80 -> RAM unchanged, misalign=1, misalign_pc=0x80; a second misaligned store at pc=0x84 leaves misalign_pc=0x80; a store of wd=1 to MMIO_BASE+8 clears both.
REQ-038 Store @0x0 and @(DEPTH_WORDS*4) with distinct data -> same word; rd returns the last value written (wrap-around).
REQ-039 Read MMIO_BASE on two consecutive cycles -> values differ by 1; force the counter to 0xFFFFFFFF -> it reads 0 on the next cycle.
REQ-040 Store 0x5A5A5A5A to MMIO_BASE+4 in the same cycle reset=1 -> led=0, trace_valid=0; repeat without reset -> led=0x5A5A5A5A.
REQ-041 Store then read the same address in the same cycle -> rd shows the old value, and the new value on the next cycle.
